// File: rtl/cpu_controller_gen2_pkg.sv
// Shared definitions for the second-generation CPU control unit:
// FSM state codes, opcode values and ALU operation selects.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_INIT   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_LOAD_A = 4'd3,
    ST_LOAD_B = 4'd4,
    ST_STORE  = 4'd5,
    ST_ADD    = 4'd6,
    ST_SUB    = 4'd7,
    ST_JUMP   = 4'd8,
    ST_HALT   = 4'd9
  } state_t;

  localparam logic [3:0] OP_NOOP  = 4'd0;
  localparam logic [3:0] OP_STORE = 4'd1;
  localparam logic [3:0] OP_LOAD  = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_HALT  = 4'd5;
  localparam logic [3:0] OP_JMP   = 4'd6;
  localparam logic [3:0] OP_JZ    = 4'd7;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;

endpackage

// File: rtl/cpu_controller_gen2_if.sv
// Instruction-memory fetch bus: the controller requests an address and the
// memory answers with a one-cycle valid pulse carrying the instruction.
interface cpu_controller_gen2_if #(
  parameter int PC_W    = 7,
  parameter int INSTR_W = 16
);
  logic               IMem_Req;
  logic [PC_W-1:0]    IMem_Addr;
  logic               IMem_Valid;
  logic [INSTR_W-1:0] IMem_Data;

  modport master (
    output IMem_Req,
    output IMem_Addr,
    input  IMem_Valid,
    input  IMem_Data
  );

  modport slave (
    input  IMem_Req,
    input  IMem_Addr,
    output IMem_Valid,
    output IMem_Data
  );
endinterface

// File: rtl/cpu_controller_gen2_pc.sv
// Program counter: synchronous clear, parallel load and increment,
// with clear taking priority over load and load over increment.
module cpu_pc #(
  parameter int PC_W = 7
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            ld,
  input  logic            up,
  input  logic [PC_W-1:0] ld_val,
  output logic [PC_W-1:0] pc
);

  localparam logic [PC_W-1:0] ONE = {{(PC_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (clr)
      pc <= '0;
    else if (ld)
      pc <= ld_val;
    else if (up)
      pc <= pc + ONE;
  end

endmodule

// File: rtl/cpu_controller_gen2.sv
// Control unit for the 16-bit CPU: PC, instruction register and control FSM
// fetching over a variable-latency req/valid instruction bus.
module cpu_controller_gen2
  import cpu_ctrl_pkg::*;
#(
  parameter  int PC_W    = 7,
  parameter  int RF_AW   = 4,
  localparam int INSTR_W = 4 + 3*RF_AW,
  localparam int D_AW    = 2*RF_AW
) (
  input  logic               Clk,
  input  logic               Rst,
  cpu_controller_gen2_if.master imem,
  input  logic               ALU_Zero,
  output logic [PC_W-1:0]    PC_Out,
  output logic [INSTR_W-1:0] IR_Out,
  output logic [3:0]         State_Out,
  output logic [3:0]         NextState_Out,
  output logic [D_AW-1:0]    D_Addr,
  output logic               D_Wr,
  output logic               RF_s,
  output logic               RF_W_en,
  output logic [RF_AW-1:0]   RF_Ra_Addr,
  output logic [RF_AW-1:0]   RF_Rb_Addr,
  output logic [RF_AW-1:0]   RF_W_Addr,
  output logic [2:0]         ALU_s,
  output logic               Halted,
  output logic               Illegal_Op
);

  state_t             state_q, state_d;
  logic [INSTR_W-1:0] ir_q;
  logic               z_q;
  logic               illegal_q;

  logic               ir_ld, pc_up, pc_ld, z_ld, illegal_set;
  logic [PC_W-1:0]    pc_q, jmp_tgt;

  logic [3:0]         op;
  logic [RF_AW-1:0]   f2, f1, f0;
  logic [D_AW-1:0]    addr;

  assign op   = ir_q[INSTR_W-1 -: 4];
  assign f2   = ir_q[3*RF_AW-1 -: RF_AW];
  assign f1   = ir_q[2*RF_AW-1 -: RF_AW];
  assign f0   = ir_q[RF_AW-1:0];
  assign addr = {f2, f1};

  // Jump target is the address field truncated or zero-extended to the PC.
  generate
    if (PC_W <= D_AW) begin : g_tgt_trunc
      assign jmp_tgt = addr[PC_W-1:0];
    end else begin : g_tgt_ext
      assign jmp_tgt = {{(PC_W-D_AW){1'b0}}, addr};
    end
  endgenerate

  cpu_pc #(.PC_W(PC_W)) u_pc (
    .clk    (Clk),
    .clr    (Rst || (state_q == ST_INIT)),
    .ld     (pc_ld),
    .up     (pc_up),
    .ld_val (jmp_tgt),
    .pc     (pc_q)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= ST_INIT;
      ir_q      <= '0;
      z_q       <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ir_ld)       ir_q      <= imem.IMem_Data;
      if (z_ld)        z_q       <= ALU_Zero;
      if (illegal_set) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_d        = state_q;
    ir_ld          = 1'b0;
    pc_up          = 1'b0;
    pc_ld          = 1'b0;
    z_ld           = 1'b0;
    illegal_set    = 1'b0;
    imem.IMem_Req  = 1'b0;
    D_Addr         = '0;
    D_Wr           = 1'b0;
    RF_s           = 1'b0;
    RF_W_en        = 1'b0;
    RF_Ra_Addr     = '0;
    RF_Rb_Addr     = '0;
    RF_W_Addr      = '0;
    ALU_s          = ALU_PASS;
    Halted         = 1'b0;

    case (state_q)
      ST_INIT: state_d = ST_FETCH;
      ST_FETCH: begin
        imem.IMem_Req = 1'b1;
        if (imem.IMem_Valid) begin
          ir_ld   = 1'b1;
          pc_up   = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (op)
          OP_NOOP:  state_d = ST_FETCH;
          OP_STORE: state_d = ST_STORE;
          OP_LOAD:  state_d = ST_LOAD_A;
          OP_ADD:   state_d = ST_ADD;
          OP_SUB:   state_d = ST_SUB;
          OP_HALT:  state_d = ST_HALT;
          OP_JMP:   state_d = ST_JUMP;
          OP_JZ:    state_d = z_q ? ST_JUMP : ST_FETCH;
          default: begin
            illegal_set = 1'b1;
            state_d     = ST_FETCH;
          end
        endcase
      end
      // LOAD_A gives the synchronous data memory a cycle before the write.
      ST_LOAD_A, ST_LOAD_B: begin
        D_Addr    = addr;
        RF_s      = 1'b1;
        RF_W_Addr = f0;
        RF_W_en   = (state_q == ST_LOAD_B);
        state_d   = (state_q == ST_LOAD_A) ? ST_LOAD_B : ST_FETCH;
      end
      ST_STORE: begin
        D_Addr     = addr;
        RF_Ra_Addr = f0;
        D_Wr       = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_ADD, ST_SUB: begin
        RF_Ra_Addr = f2;
        RF_Rb_Addr = f1;
        RF_W_Addr  = f0;
        RF_W_en    = 1'b1;
        ALU_s      = (state_q == ST_ADD) ? ALU_ADD : ALU_SUB;
        z_ld       = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_JUMP: begin
        pc_ld   = 1'b1;
        state_d = ST_FETCH;
      end
      ST_HALT: Halted = 1'b1;
      default: state_d = ST_INIT;
    endcase
  end

  assign imem.IMem_Addr = pc_q;
  assign PC_Out         = pc_q;
  assign IR_Out         = ir_q;
  assign State_Out      = state_q;
  assign NextState_Out  = state_d;
  assign Illegal_Op     = illegal_q;

endmodule
